// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared defaults, frame state encoding and sample-triplet type
// for the ADC SPI responder.
package adc_resp_pkg;

    localparam int DATA_W_DEF     = 12;
    localparam int FRAME_BITS_DEF = 16;
    localparam int LEAD_ZEROS     = FRAME_BITS_DEF - DATA_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One conversion result per pixel channel, packed as {ch2, ch1, ch0}.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] ch2;
        logic [DATA_W_DEF-1:0] ch1;
        logic [DATA_W_DEF-1:0] ch0;
    } triplet_t;

endpackage

// File: rtl/adc_resp_fifo.sv
// adc_resp_fifo: small synchronous FIFO holding sample triplets. The head entry
// is visible combinationally. Push and pop may occur in the same cycle.
module adc_resp_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    output logic                     o_ready,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_nempty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_ready   = (r_level != LW'(DEPTH));
    assign o_nempty  = (r_level != '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && o_ready;
    assign w_pop_ok  = i_pop && o_nempty;

    // Storage array; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: slave-side stand-in for the three pixel ADCs. It answers
// the reader's shared cs_n/sclk with frames of leading zeros followed by a
// DATA_W-bit sample, MSB first, updated after each sclk falling edge.
// Optional build macro: ADC_RESP_RAMP_EN makes underrun frames carry a
// per-channel ramp instead of zeros.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cs_n,
    input  logic                         sclk,
    output logic                         px0_adc_din,
    output logic                         px1_adc_din,
    output logic                         px2_adc_din,
    input  logic                         s_valid,
    input  logic [3*DATA_W-1:0]          s_data,
    output logic                         s_ready,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic                         frame_done,
    output logic                         frame_abort,
    output logic                         underrun
);
    localparam int CW = $clog2(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0]        r_cs_sync;
    logic [SYNC_STAGES-1:0]        r_sclk_sync;
    logic                          r_cs_last;
    logic                          r_sclk_last;
    logic                          r_cs_fall;
    logic                          r_cs_rise;
    logic                          r_sclk_fall;
    logic                          w_cs_s;
    logic                          w_sclk_s;

    state_t                        r_state;
    logic [CW-1:0]                 r_bitcnt;
    logic [2:0][FRAME_BITS-1:0]    r_sh;
    logic                          r_done;
    logic                          r_abort;
    logic                          r_under;

    logic [3*DATA_W-1:0]           w_head;
    logic                          w_nempty;
    logic                          w_start;
    logic                          w_pop;
    logic                          w_under_take;
    logic [2:0][DATA_W-1:0]        w_under_word;

    assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_start      = (r_state == IDLE) && r_cs_fall;
    assign w_pop        = w_start && w_nempty;
    assign w_under_take = w_start && !w_nempty;

    adc_resp_fifo #(
        .W     (3*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (s_valid),
        .i_data   (s_data),
        .o_ready  (s_ready),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_nempty (w_nempty),
        .o_level  (level)
    );

    // Synchronize cs_n/sclk and register their edges. Chains reset low so a
    // cs_n already low at reset release never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_cs_last   <= 1'b0;
            r_sclk_last <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_sclk_fall <= 1'b0;
        end else begin
            r_cs_sync[0]   <= cs_n;
            r_sclk_sync[0] <= sclk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_sclk_sync[i] <= r_sclk_sync[i-1];
            end
            r_cs_last   <= w_cs_s;
            r_sclk_last <= w_sclk_s;
            r_cs_fall   <= r_cs_last & ~w_cs_s;
            r_cs_rise   <= ~r_cs_last & w_cs_s;
            r_sclk_fall <= r_sclk_last & ~w_sclk_s;
        end
    end

`ifdef ADC_RESP_RAMP_EN
    logic [2:0][DATA_W-1:0] r_ramp;

    assign w_under_word = r_ramp;

    // Ramp counters: channel n starts at n and steps by 3 per underrun frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 3; n++) begin
                r_ramp[n] <= DATA_W'(n);
            end
        end else if (w_under_take) begin
            for (int n = 0; n < 3; n++) begin
                r_ramp[n] <= r_ramp[n] + DATA_W'(3);
            end
        end
    end
`else
    assign w_under_word = '0;
`endif

    // Frame FSM: load on cs_n fall, shift on sclk fall, cs_n rise wins over sclk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_sh     <= '0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_under <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_cs_fall) begin
                        r_bitcnt <= '0;
                        r_state  <= SHIFT;
                        for (int ch = 0; ch < 3; ch++) begin
                            if (w_nempty) begin
                                r_sh[ch] <= FRAME_BITS'(w_head[ch*DATA_W +: DATA_W]);
                            end else begin
                                r_sh[ch] <= FRAME_BITS'(w_under_word[ch]);
                            end
                        end
                        r_under <= !w_nempty;
                    end
                end
                SHIFT: begin
                    if (r_cs_rise) begin
                        r_sh    <= '0;
                        r_abort <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_sclk_fall) begin
                        if (r_bitcnt == CW'(FRAME_BITS - 1)) begin
                            r_sh    <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            for (int ch = 0; ch < 3; ch++) begin
                                r_sh[ch] <= r_sh[ch] << 1;
                            end
                            r_bitcnt <= r_bitcnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (r_cs_rise) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_sh    <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign px0_adc_din = r_sh[0][FRAME_BITS-1];
    assign px1_adc_din = r_sh[1][FRAME_BITS-1];
    assign px2_adc_din = r_sh[2][FRAME_BITS-1];
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign underrun    = r_under;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed checks of the ADC SPI responder with a
// behavioural reader driving cs_n/sclk at clk/8 and capturing din before each
// sclk falling edge.
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        sclk;
    logic        px0, px1, px2;
    logic        s_valid;
    logic [35:0] s_data;
    logic        s_ready;
    logic [2:0]  level;
    logic        frame_done, frame_abort, underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int under_cnt = 0;

    always #10 clk = ~clk;

    adc_spi_responder dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .px0_adc_din (px0),
        .px1_adc_din (px1),
        .px2_adc_din (px2),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .level       (level),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .underrun    (underrun)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done)  done_cnt  = done_cnt + 1;
        if (frame_abort) abort_cnt = abort_cnt + 1;
        if (underrun)    under_cnt = under_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [35:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // One cs_n window with nsclk sclk cycles; abort_at>=0 raises cs_n after that many.
    task automatic run_frame(input int nsclk, input int abort_at,
                             output logic [47:0] got, output bit extra_nz);
        got = '0;
        extra_nz = 1'b0;
        @(negedge clk);
        cs_n = 1'b1;
        sclk = 1'b1;
        wait_clk(8);
        cs_n = 1'b0;
        wait_clk(8);
        for (int k = 0; k < nsclk; k++) begin
            if (k == abort_at) break;
            if (k < 16) begin
                got[15:0]  = {got[14:0],  px0};
                got[31:16] = {got[30:16], px1};
                got[47:32] = {got[46:32], px2};
            end else if (px0 || px1 || px2) begin
                extra_nz = 1'b1;
            end
            sclk = 1'b0;
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
        end
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; cs_n = 1'b1; sclk = 1'b1; s_valid = 1'b0; s_data = '0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(10);
        n_tests++;
        if ({px2, px1, px0} !== 3'b000) begin
            n_fail++; $display("FAIL reset_din: got %b want 000", {px2, px1, px0});
        end
        n_tests++;
        if (level !== 3'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d want 0", level);
        end
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", s_ready);
        end
        n_tests++;
        if ({frame_done, frame_abort, underrun} !== 3'b000 || done_cnt + abort_cnt + under_cnt != 0) begin
            n_fail++; $display("FAIL reset_pulses: got %0d pulses want 0", done_cnt + abort_cnt + under_cnt);
        end
    endtask

    task automatic test_basic;
        logic [47:0] got;
        bit nz;
        int d0;
        push({12'hFFF, 12'h123, 12'hABC});
        n_tests++;
        if (level !== 3'd1) begin
            n_fail++; $display("FAIL basic_level_push: got %0d want 1", level);
        end
        d0 = done_cnt;
        run_frame(16, -1, got, nz);
        n_tests++;
        if (got !== {16'h0FFF, 16'h0123, 16'h0ABC}) begin
            n_fail++; $display("FAIL basic_stream: got %h want 0fff01230abc", got);
        end
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
        end
        n_tests++;
        if (level !== 3'd0) begin
            n_fail++; $display("FAIL basic_level_pop: got %0d want 0", level);
        end
        n_tests++;
        if ({px2, px1, px0} !== 3'b000) begin
            n_fail++; $display("FAIL basic_din_idle: got %b want 000", {px2, px1, px0});
        end
    endtask

    task automatic test_fill;
        logic [35:0] tv [5];
        logic [35:0] t;
        logic [47:0] got;
        logic [47:0] exp;
        bit nz;
        tv[0] = 36'h001002003;
        tv[1] = 36'h456789ABC;
        tv[2] = 36'hFED000800;
        tv[3] = 36'h0F0F0F0F0;
        tv[4] = 36'h777777777;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (s_ready !== (i < 4)) begin
                n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", i, s_ready, (i < 4));
            end
            push(tv[i]);
        end
        n_tests++;
        if (level !== 3'd4) begin
            n_fail++; $display("FAIL fill_level: got %0d want 4", level);
        end
        for (int i = 0; i < 4; i++) begin
            t = tv[i];
            exp = {4'h0, t[35:24], 4'h0, t[23:12], 4'h0, t[11:0]};
            run_frame(16, -1, got, nz);
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL fill_frame_%0d: got %h want %h", i, got, exp);
            end
        end
        n_tests++;
        if (level !== 3'd0) begin
            n_fail++; $display("FAIL fill_drained: got %0d want 0", level);
        end
    endtask

    task automatic test_underrun;
        logic [47:0] got;
        logic [47:0] exp1, exp2;
        bit nz;
        int u0;
`ifdef ADC_RESP_RAMP_EN
        exp1 = {16'd2, 16'd1, 16'd0};
        exp2 = {16'd5, 16'd4, 16'd3};
`else
        exp1 = '0;
        exp2 = '0;
`endif
        u0 = under_cnt;
        run_frame(16, -1, got, nz);
        n_tests++;
        if (under_cnt - u0 != 1) begin
            n_fail++; $display("FAIL under_pulse: got %0d pulses want 1", under_cnt - u0);
        end
        n_tests++;
        if (got !== exp1) begin
            n_fail++; $display("FAIL under_word1: got %h want %h", got, exp1);
        end
        run_frame(16, -1, got, nz);
        n_tests++;
        if (got !== exp2 || under_cnt - u0 != 2) begin
            n_fail++; $display("FAIL under_word2: got %h/%0d want %h/2", got, under_cnt - u0, exp2);
        end
    endtask

    task automatic test_abort;
        logic [47:0] got;
        bit nz;
        int a0, d0;
        push({12'h111, 12'h222, 12'h333});
        push({12'hC0D, 12'hE0F, 12'h5A5});
        a0 = abort_cnt;
        d0 = done_cnt;
        run_frame(16, 7, got, nz);
        n_tests++;
        if (abort_cnt - a0 != 1 || done_cnt - d0 != 0) begin
            n_fail++; $display("FAIL abort_pulse: got abort %0d done %0d want 1 0", abort_cnt - a0, done_cnt - d0);
        end
        n_tests++;
        if ({px2, px1, px0} !== 3'b000) begin
            n_fail++; $display("FAIL abort_din: got %b want 000", {px2, px1, px0});
        end
        n_tests++;
        if (level !== 3'd1) begin
            n_fail++; $display("FAIL abort_level: got %0d want 1", level);
        end
        run_frame(16, -1, got, nz);
        n_tests++;
        if (got !== {16'h0C0D, 16'h0E0F, 16'h05A5}) begin
            n_fail++; $display("FAIL abort_next: got %h want 0c0d0e0f05a5", got);
        end
    endtask

    task automatic test_extra_sclk;
        logic [47:0] got;
        bit nz;
        int d0;
        push({12'h800, 12'h001, 12'h7FE});
        push({12'h0AA, 12'h0BB, 12'h0CC});
        d0 = done_cnt;
        run_frame(20, -1, got, nz);
        n_tests++;
        if (got !== {16'h0800, 16'h0001, 16'h07FE}) begin
            n_fail++; $display("FAIL extra_stream: got %h want 0800000107fe", got);
        end
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL extra_done: got %0d pulses want 1", done_cnt - d0);
        end
        n_tests++;
        if (nz !== 1'b0) begin
            n_fail++; $display("FAIL extra_din_zero: got %b want 0", nz);
        end
        n_tests++;
        if (level !== 3'd1) begin
            n_fail++; $display("FAIL extra_level: got %0d want 1", level);
        end
    endtask

    task automatic test_reset_mid;
        logic [47:0] got;
        bit nz;
        int d0, a0, u0;
        push({12'h321, 12'h654, 12'h987});
        push({12'h135, 12'h246, 12'h357});
        @(negedge clk);
        cs_n = 1'b1; sclk = 1'b1;
        wait_clk(8);
        cs_n = 1'b0;
        wait_clk(8);
        for (int k = 0; k < 3; k++) begin
            sclk = 1'b0; wait_clk(4);
            sclk = 1'b1; wait_clk(4);
        end
        d0 = done_cnt; a0 = abort_cnt; u0 = under_cnt;
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        n_tests++;
        if ({px2, px1, px0} !== 3'b000 || level !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_state: got din %b level %0d want 000 0", {px2, px1, px0}, level);
        end
        for (int k = 0; k < 4; k++) begin
            sclk = 1'b0; wait_clk(4);
            sclk = 1'b1; wait_clk(4);
        end
        n_tests++;
        if (done_cnt != d0 || abort_cnt != a0 || under_cnt != u0 || {px2, px1, px0} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_quiet: got done %0d abort %0d under %0d din %b want 0 0 0 000",
                               done_cnt - d0, abort_cnt - a0, under_cnt - u0, {px2, px1, px0});
        end
        push({12'h9C3, 12'h06D, 12'hF00});
        run_frame(16, -1, got, nz);
        n_tests++;
        if (got !== {16'h09C3, 16'h006D, 16'h0F00} || done_cnt - d0 != 1 || under_cnt != u0) begin
            n_fail++; $display("FAIL rstmid_recover: got %h done %0d want 09c3006d0f00 done 1", got, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underrun();
        test_abort();
        test_extra_sclk();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
